// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the RV32M multiply/divide engine.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    // Pipeline side: issues operations and observes stall/result
    modport master (
        output start_i, op_i, rs1_i, rs2_i, flush_i,
        input  busy_o, valid_o, result_o
    );

    // Engine side
    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, flush_i,
        output busy_o, valid_o, result_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide engine. Works on operand magnitudes for
// XLEN cycles, applies the sign in a dedicated FIX cycle, then pulses valid_o.
// Divide-by-zero and signed overflow bypass the iteration entirely.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t          r_state;
    logic [2:0]      r_op;
    logic            r_neg;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_opnd;   // multiplicand |A| for multiply, divisor |B| for divide
    logic [XLEN-1:0] r_hi;     // product high half / partial remainder
    logic [XLEN-1:0] r_lo;     // multiplier->product low half / dividend->quotient
    logic [XLEN-1:0] r_result;
    logic            r_valid;

    logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic            w_div_zero, w_div_ovf, w_special;
    logic [XLEN-1:0] w_special_res;
    logic [XLEN:0]   w_sum;
    logic [XLEN-1:0] w_mul_hi, w_mul_lo;
    logic [XLEN:0]   w_rem_sh, w_trial;
    logic            w_qbit;
    logic [XLEN-1:0] w_div_hi, w_div_lo;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0] w_quo_s, w_rem_s, w_fix_res;

    // Operand decode at issue: signedness, magnitudes, special-case detection
    always_comb begin
        w_a_signed = bus.op_i[2] ? !bus.op_i[0] : (bus.op_i != 3'd3);
        w_b_signed = bus.op_i[2] ? !bus.op_i[0] : !bus.op_i[1];
        w_a_neg    = w_a_signed & bus.rs1_i[XLEN-1];
        w_b_neg    = w_b_signed & bus.rs2_i[XLEN-1];
        w_a_mag    = w_a_neg ? -bus.rs1_i : bus.rs1_i;
        w_b_mag    = w_b_neg ? -bus.rs2_i : bus.rs2_i;
        // Remainder follows the dividend sign; everything else the sign product
        w_neg      = (bus.op_i[2] & bus.op_i[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_div_zero = bus.op_i[2] & (bus.rs2_i == '0);
        w_div_ovf  = bus.op_i[2] & !bus.op_i[0] &
                     (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (bus.rs2_i == '1);
        w_special  = w_div_zero | w_div_ovf;
        if (w_div_zero) begin
            w_special_res = bus.op_i[1] ? bus.rs1_i : '1;
        end else begin
            w_special_res = bus.op_i[1] ? '0 : bus.rs1_i;
        end
    end

    // One shift-add or restoring-subtract step on the magnitude registers
    always_comb begin
        w_sum    = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_opnd}) : {1'b0, r_hi};
        w_mul_hi = w_sum[XLEN:1];
        w_mul_lo = {w_sum[0], r_lo[XLEN-1:1]};
        // r_hi < divisor always holds, so bit XLEN of the trial is a clean borrow flag
        w_rem_sh = {r_hi, r_lo[XLEN-1]};
        w_trial  = w_rem_sh - {1'b0, r_opnd};
        w_qbit   = !w_trial[XLEN];
        w_div_hi = w_qbit ? w_trial[XLEN-1:0] : w_rem_sh[XLEN-1:0];
        w_div_lo = {r_lo[XLEN-2:0], w_qbit};
    end

    // Sign fix-up and result-half selection used in the FIX cycle
    always_comb begin
        w_prod_s = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
        w_quo_s  = r_neg ? -r_lo : r_lo;
        w_rem_s  = r_neg ? -r_hi : r_hi;
        case (r_op)
            3'd0:                w_fix_res = w_prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    w_fix_res = w_prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:          w_fix_res = w_quo_s;
            default:             w_fix_res = w_rem_s;
        endcase
    end

    // Control FSM with registered result/valid; flush overrides every state
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_count  <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (bus.flush_i) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start_i) begin
                            r_op  <= bus.op_i;
                            r_neg <= w_neg;
                            if (w_special) begin
                                r_result <= w_special_res;
                                r_valid  <= 1'b1;
                                r_state  <= S_DONE;
                            end else begin
                                r_hi    <= '0;
                                r_lo    <= bus.op_i[2] ? w_a_mag : w_b_mag;
                                r_opnd  <= bus.op_i[2] ? w_b_mag : w_a_mag;
                                r_count <= '0;
                                r_state <= S_CALC;
                            end
                        end
                    end
                    S_CALC: begin
                        r_hi    <= r_op[2] ? w_div_hi : w_mul_hi;
                        r_lo    <= r_op[2] ? w_div_lo : w_mul_lo;
                        r_count <= r_count + CW'(1);
                        if (r_count == CW'(XLEN-1)) begin
                            r_state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        r_result <= w_fix_res;
                        r_valid  <= 1'b1;
                        r_state  <= S_DONE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Stall request: covers the accepting IDLE cycle through FIX, never during a flush
    always_comb begin
        bus.busy_o = !bus.flush_i &
                     (((r_state == S_IDLE) & bus.start_i) | (r_state == S_CALC) | (r_state == S_FIX));
    end

    assign bus.valid_o  = r_valid;
    assign bus.result_o = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver queues expected result, latency and
// busy-cycle count per operation; a negedge monitor pops and compares on valid_o.
module tb_muldiv_unit;
    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          busy;
        int          t0;
        int          b0;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   busy_total = 0;
    int   n_done = 0;
    exp_t q[$];
    exp_t e_mon;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.busy_o) busy_total++;
            if (bus.valid_o) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: result_o=%h with nothing pending", bus.result_o);
                end else begin
                    e_mon = q.pop_front();
                    check32({e_mon.name, "_result"}, bus.result_o, e_mon.res);
                    check32({e_mon.name, "_latency"}, 32'(cyc - e_mon.t0 + 1), 32'(e_mon.lat));
                    check32({e_mon.name, "_busy"}, 32'(busy_total - e_mon.b0), 32'(e_mon.busy));
                    n_done++;
                end
            end
        end
    end

    task automatic wait_done(input int prev, input string nm);
        bit got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            #1;
            if (n_done != prev) got = 1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no valid_o within 60 cycles, expected one", nm);
            q.delete();
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit special, input string nm);
        exp_t e;
        int prev;
        @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.rs1_i   = a;
        bus.rs2_i   = b;
        @(posedge clk);
        #1;
        // Scramble operands after acceptance; the engine must have latched them
        bus.start_i = 1'b0;
        bus.op_i    = ~op;
        bus.rs1_i   = ~a;
        bus.rs2_i   = b ^ 32'h5A5A_5A5A;
        e.res  = exp;
        e.lat  = special ? 1 : 34;
        e.busy = special ? 0 : 33;
        e.t0   = cyc;
        e.b0   = busy_total;
        e.name = nm;
        prev   = n_done;
        q.push_back(e);
        wait_done(prev, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_i = 1'b0;
        bus.op_i    = '0;
        bus.rs1_i   = '0;
        bus.rs2_i   = '0;
        bus.flush_i = 1'b0;
        #1 rstn = 1'b0;
        #10;
        check32("reset_busy", 32'(bus.busy_o), 32'd0);
        check32("reset_valid", 32'(bus.valid_o), 32'd0);
        check32("reset_result", bus.result_o, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        run_op(MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, "mul_7_m3");
        run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu_ff");
        run_op(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, "mulh_ff");
        run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_ff");
        run_op(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "mulh_min");
        run_op(MULHSU, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 0, "mulhsu_min2");
        run_op(MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0, "mul_2p32");
        run_op(MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 0, "mulhu_2p32");
        run_op(DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, "div_m7_2");
        run_op(REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0, "rem_m7_2");
        run_op(DIVU,   32'd100,       32'd7,         32'd14,        0, "divu_100_7");
        run_op(REMU,   32'd100,       32'd7,         32'd2,         0, "remu_100_7");
        run_op(DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, "div_7_m2");
        run_op(REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         0, "rem_7_m2");
        run_op(DIV,    32'h8000_0000, 32'd2,         32'hC000_0000, 0, "div_min_2");
        run_op(DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 0, "divu_ff_1");
        run_op(REMU,   32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 0, "remu_ff_16");
        run_op(DIVU,   32'h1234,      32'd0,         32'hFFFF_FFFF, 1, "divu_by0");
        run_op(REMU,   32'h1234,      32'd0,         32'h0000_1234, 1, "remu_by0");
        run_op(DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1, "div_by0");
        run_op(REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1, "rem_by0");
        run_op(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run_op(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf");
        run_op(DIVU,   32'd1000,      32'd3,         32'd333,       0, "divu_1000_3");

        // Flush during CALC cycle 10: no result, result_o keeps the previous value
        @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.op_i    = DIV;
        bus.rs1_i   = 32'd1000;
        bus.rs2_i   = 32'd3;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        @(negedge clk);
        check32("flush_busy_during", 32'(bus.busy_o), 32'd0);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        check32("flush_busy_after", 32'(bus.busy_o), 32'd0);
        check32("flush_result_hold", bus.result_o, 32'd333);
        repeat (40) @(negedge clk);

        // Flush wins over a simultaneous start
        @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.op_i    = MUL;
        bus.rs1_i   = 32'd9;
        bus.rs2_i   = 32'd9;
        @(negedge clk);
        check32("flushstart_busy", 32'(bus.busy_o), 32'd0);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        @(negedge clk);
        check32("flushstart_idle", 32'(bus.busy_o), 32'd0);
        repeat (40) @(negedge clk);

        run_op(MUL, 32'd3, 32'd5, 32'd15, 0, "mul_3_5");

        // Asynchronous reset in the middle of CALC
        @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.op_i    = DIV;
        bus.rs1_i   = 32'd1000;
        bus.rs2_i   = 32'd3;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check32("midreset_busy", 32'(bus.busy_o), 32'd0);
        check32("midreset_valid", 32'(bus.valid_o), 32'd0);
        check32("midreset_result", bus.result_o, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.valid_o) begin
                check32("postreset_valid", 32'(bus.valid_o), 32'd0);
            end
        end
        check32("postreset_busy", 32'(bus.busy_o), 32'd0);
        check32("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
